// File: rtl/caca_niquel_pkg.sv
// Shared definitions for the three-reel slot machine: FSM state encoding,
// reel defaults common with the counter block, and the prize classifier.
package caca_niquel_pkg;

  localparam int NBITS_CONTADOR_PAD = 4;
  localparam int FIM_PAD            = 6;
  localparam int NBITS_CREDITO_PAD  = 8;

  typedef enum logic [1:0] {
    GIRANDO     = 2'd0,
    AVALIA      = 2'd1,
    RESULTADO   = 2'd2,
    SEM_CREDITO = 2'd3
  } estado_t;

  // Reels above fim are plain values here: only equality matters.
  function automatic int unsigned classifica(
    input int unsigned a,
    input int unsigned b,
    input int unsigned c,
    input int unsigned fim,
    input int unsigned par,
    input int unsigned trio,
    input int unsigned jackpot
  );
    if (a == b && b == c)
      return (a == fim) ? jackpot : trio;
    else if (a == b || b == c || a == c)
      return par;
    else
      return 0;
  endfunction

endpackage

// File: rtl/slot_payout_if.sv
// Reel lock/value inputs and credit/status outputs of the payout stage.
interface slot_payout_if
  import caca_niquel_pkg::*;
#(
  parameter int NBITS_CONTADOR = NBITS_CONTADOR_PAD,
  parameter int NBITS_CREDITO  = NBITS_CREDITO_PAD
);

  logic                      trava1;
  logic                      trava2;
  logic                      trava3;
  logic [NBITS_CONTADOR-1:0] contador1;
  logic [NBITS_CONTADOR-1:0] contador2;
  logic [NBITS_CONTADOR-1:0] contador3;
  logic [NBITS_CREDITO-1:0]  credito;
  logic [NBITS_CREDITO-1:0]  premio;
  logic [7:0]                rodadas;
  logic [1:0]                estado;
  logic                      ganhou;

  modport master (
    output trava1, trava2, trava3, contador1, contador2, contador3,
    input  credito, premio, rodadas, estado, ganhou
  );

  modport slave (
    input  trava1, trava2, trava3, contador1, contador2, contador3,
    output credito, premio, rodadas, estado, ganhou
  );

endinterface

// File: rtl/pisca_led.sv
// Win-lamp blinker: loads high on start, then toggles every NPISCA enabled
// cycles; synchronous clear forces it low.
module pisca_led #(
  parameter int NPISCA = 4
) (
  input  logic clk_2,
  input  logic clr,
  input  logic inicia,
  input  logic en,
  output logic saida
);

  localparam int W = (NPISCA > 1) ? $clog2(NPISCA) : 1;
  localparam logic [W-1:0] ULTIMO = W'(NPISCA - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk_2) begin
    if (inicia) begin
      cnt   <= '0;
      saida <= 1'b1;
    end else if (clr) begin
      cnt   <= '0;
      saida <= 1'b0;
    end else if (en) begin
      if (cnt == ULTIMO) begin
        cnt   <= '0;
        saida <= ~saida;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/slot_payout.sv
// Round evaluation after the reel counters: snapshots locked reels, pays the
// prize minus the bet with saturation, and keeps balance and round count.
module slot_payout
  import caca_niquel_pkg::*;
#(
  parameter int NBITS_CONTADOR  = NBITS_CONTADOR_PAD,
  parameter int FIM             = FIM_PAD,
  parameter int NBITS_CREDITO   = NBITS_CREDITO_PAD,
  parameter int CREDITO_INICIAL = 10,
  parameter int APOSTA          = 1,
  parameter int PREMIO_PAR      = 2,
  parameter int PREMIO_TRIO     = 10,
  parameter int PREMIO_JACKPOT  = 20,
  parameter int NPISCA          = 4
) (
  input  logic          clk_2,
  input  logic          reinicia,
  slot_payout_if.slave  bus
);

  localparam logic [NBITS_CREDITO-1:0] APOSTA_N  = NBITS_CREDITO'(APOSTA);
  localparam logic [NBITS_CREDITO:0]   APOSTA_N1 = (NBITS_CREDITO + 1)'(APOSTA);
  localparam logic [NBITS_CREDITO-1:0] CRED_INI  = NBITS_CREDITO'(CREDITO_INICIAL);

  estado_t                   estado;
  logic                      todas;
  logic                      todas_q;
  logic [NBITS_CONTADOR-1:0] snap1;
  logic [NBITS_CONTADOR-1:0] snap2;
  logic [NBITS_CONTADOR-1:0] snap3;
  logic [NBITS_CREDITO-1:0]  credito;
  logic [NBITS_CREDITO-1:0]  premio;
  logic [7:0]                rodadas;
  logic [NBITS_CREDITO-1:0]  premio_calc;
  logic [NBITS_CREDITO:0]    soma;
  logic [NBITS_CREDITO-1:0]  credito_novo;
  logic                      pisca_inicia;
  logic                      pisca_clr;
  logic                      pisca_en;
  logic                      ganhou;

  assign todas = bus.trava1 & bus.trava2 & bus.trava3;

  // One extra bit holds the sum; overflow into it means saturate.
  always_comb begin
    premio_calc = NBITS_CREDITO'(classifica(32'(snap1), 32'(snap2), 32'(snap3),
                                            FIM, PREMIO_PAR, PREMIO_TRIO,
                                            PREMIO_JACKPOT));
    soma = {1'b0, credito} - APOSTA_N1 + {1'b0, premio_calc};
    credito_novo = soma[NBITS_CREDITO] ? '1 : soma[NBITS_CREDITO-1:0];
  end

  always_ff @(posedge clk_2) begin
    if (reinicia) begin
      estado  <= GIRANDO;
      todas_q <= 1'b1;
      snap1   <= '0;
      snap2   <= '0;
      snap3   <= '0;
      credito <= CRED_INI;
      premio  <= '0;
      rodadas <= '0;
    end else begin
      todas_q <= todas;
      case (estado)
        GIRANDO: begin
          if (todas && !todas_q) begin
            snap1  <= bus.contador1;
            snap2  <= bus.contador2;
            snap3  <= bus.contador3;
            estado <= AVALIA;
          end
        end
        AVALIA: begin
          premio  <= premio_calc;
          credito <= credito_novo;
          rodadas <= rodadas + 8'd1;
          estado  <= RESULTADO;
        end
        RESULTADO: begin
          if (!todas)
            estado <= (credito >= APOSTA_N) ? GIRANDO : SEM_CREDITO;
        end
        SEM_CREDITO: estado <= SEM_CREDITO;
        default:     estado <= GIRANDO;
      endcase
    end
  end

  // The lamp is loaded on the same edge that enters RESULTADO so it is high
  // from the first RESULTADO cycle; any exit from RESULTADO clears it.
  always_comb begin
    pisca_inicia = !reinicia && (estado == AVALIA) && (premio_calc != '0);
    pisca_clr    = reinicia || (estado != RESULTADO) || !todas;
    pisca_en     = (estado == RESULTADO);
  end

  pisca_led #(
    .NPISCA (NPISCA)
  ) u_pisca (
    .clk_2  (clk_2),
    .clr    (pisca_clr),
    .inicia (pisca_inicia),
    .en     (pisca_en),
    .saida  (ganhou)
  );

  assign bus.credito = credito;
  assign bus.premio  = premio;
  assign bus.rodadas = rodadas;
  assign bus.estado  = estado;
  assign bus.ganhou  = ganhou;

endmodule

// File: tb/tb_slot_payout.sv
// Directed bench for slot_payout: default instance plus a CREDITO_INICIAL=250
// instance sharing the same reel stimulus to exercise saturation.
module tb_slot_payout;

  logic clk_2;
  logic reinicia;
  int   checks;
  int   failures;

  slot_payout_if #(.NBITS_CONTADOR(4), .NBITS_CREDITO(8)) bus ();
  slot_payout_if #(.NBITS_CONTADOR(4), .NBITS_CREDITO(8)) bus_b ();

  slot_payout dut (
    .clk_2    (clk_2),
    .reinicia (reinicia),
    .bus      (bus)
  );

  slot_payout #(
    .CREDITO_INICIAL (250)
  ) dut_b (
    .clk_2    (clk_2),
    .reinicia (reinicia),
    .bus      (bus_b)
  );

  assign bus_b.trava1    = bus.trava1;
  assign bus_b.trava2    = bus.trava2;
  assign bus_b.trava3    = bus.trava3;
  assign bus_b.contador1 = bus.contador1;
  assign bus_b.contador2 = bus.contador2;
  assign bus_b.contador3 = bus.contador3;

  initial clk_2 = 1'b0;
  always #5 clk_2 = ~clk_2;

  task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    checks++;
    if (obs !== esp) begin
      failures++;
      $display("FAIL %s obtido=%0d esperado=%0d", tag, obs, esp);
    end
  endtask

  task automatic ciclos(input int n);
    repeat (n) @(negedge clk_2);
  endtask

  task automatic reseta();
    reinicia = 1'b1;
    ciclos(2);
    reinicia = 1'b0;
    ciclos(1);
  endtask

  task automatic trava_todas(input logic v);
    bus.trava1 = v;
    bus.trava2 = v;
    bus.trava3 = v;
  endtask

  task automatic rodada(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    bus.contador1 = a;
    bus.contador2 = b;
    bus.contador3 = c;
    trava_todas(1'b1);
    ciclos(2);
  endtask

  task automatic libera();
    trava_todas(1'b0);
    ciclos(2);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reinicia = 1'b1;
    trava_todas(1'b0);
    bus.contador1 = '0;
    bus.contador2 = '0;
    bus.contador3 = '0;
    ciclos(1);
    reseta();

    verifica("rst_credito", 32'(bus.credito), 10);
    verifica("rst_premio",  32'(bus.premio),  0);
    verifica("rst_rodadas", 32'(bus.rodadas), 0);
    verifica("rst_estado",  32'(bus.estado),  0);
    verifica("rst_ganhou",  32'(bus.ganhou),  0);
    verifica("rst_credito_b", 32'(bus_b.credito), 250);

    // Trio 3,3,3: 10 - 1 + 10 = 19; instance B 250 - 1 + 10 saturates
    rodada(4'd3, 4'd3, 4'd3);
    verifica("trio_credito", 32'(bus.credito), 19);
    verifica("trio_premio",  32'(bus.premio),  10);
    verifica("trio_rodadas", 32'(bus.rodadas), 1);
    verifica("trio_estado",  32'(bus.estado),  2);
    verifica("trio_sat_b",   32'(bus_b.credito), 255);
    for (int i = 0; i < 12; i++) begin
      verifica($sformatf("pisca_%0d", i), 32'(bus.ganhou), ((i / 4) % 2 == 0) ? 1 : 0);
      ciclos(1);
    end
    trava_todas(1'b0);
    ciclos(1);
    verifica("libera_estado", 32'(bus.estado), 0);
    verifica("libera_ganhou", 32'(bus.ganhou), 0);
    ciclos(1);

    // Pair, loss, jackpot from a fresh balance
    reseta();
    rodada(4'd2, 4'd5, 4'd2);
    verifica("par_credito", 32'(bus.credito), 11);
    verifica("par_premio",  32'(bus.premio),  2);
    verifica("par_ganhou",  32'(bus.ganhou),  1);
    verifica("par_credito_b", 32'(bus_b.credito), 251);
    libera();
    rodada(4'd1, 4'd2, 4'd3);
    verifica("nada_credito", 32'(bus.credito), 10);
    verifica("nada_premio",  32'(bus.premio),  0);
    verifica("nada_ganhou",  32'(bus.ganhou),  0);
    verifica("nada_rodadas", 32'(bus.rodadas), 2);
    libera();
    rodada(4'd6, 4'd6, 4'd6);
    verifica("jack_premio",  32'(bus.premio),  20);
    verifica("jack_credito", 32'(bus.credito), 29);
    verifica("jack_sat_b",   32'(bus_b.credito), 255);
    libera();

    // Value above FIM: plain trio, not jackpot
    rodada(4'd9, 4'd9, 4'd9);
    verifica("acima_fim_premio", 32'(bus.premio), 10);
    libera();

    // Drain to zero credit
    reseta();
    for (int i = 0; i < 10; i++) begin
      rodada(4'd1, 4'd2, 4'd3);
      libera();
    end
    verifica("zero_credito", 32'(bus.credito), 0);
    verifica("zero_estado",  32'(bus.estado),  3);
    verifica("zero_rodadas", 32'(bus.rodadas), 10);
    rodada(4'd3, 4'd3, 4'd3);
    ciclos(2);
    verifica("sem_cred_credito", 32'(bus.credito), 0);
    verifica("sem_cred_rodadas", 32'(bus.rodadas), 10);
    verifica("sem_cred_estado",  32'(bus.estado),  3);
    libera();
    reseta();
    verifica("volta_credito", 32'(bus.credito), 10);
    verifica("volta_estado",  32'(bus.estado),  0);

    // Locks held through reset start nothing until one is released
    trava_todas(1'b1);
    bus.contador1 = 4'd1;
    bus.contador2 = 4'd2;
    bus.contador3 = 4'd3;
    reseta();
    ciclos(3);
    verifica("preso_rodadas", 32'(bus.rodadas), 0);
    verifica("preso_estado",  32'(bus.estado),  0);
    bus.trava2 = 1'b0;
    ciclos(1);
    bus.trava2 = 1'b1;
    ciclos(2);
    verifica("retrava_rodadas", 32'(bus.rodadas), 1);
    verifica("retrava_credito", 32'(bus.credito), 9);
    ciclos(3);
    verifica("retrava_unica", 32'(bus.rodadas), 1);
    libera();

    // Lock dropped during AVALIA: RESULTADO for one cycle, then GIRANDO
    trava_todas(1'b1);
    ciclos(1);
    verifica("queda_avalia", 32'(bus.estado), 1);
    bus.trava1 = 1'b0;
    ciclos(1);
    verifica("queda_resultado", 32'(bus.estado), 2);
    ciclos(1);
    verifica("queda_girando", 32'(bus.estado), 0);
    libera();

    // Reset during AVALIA: no debit, no round counted
    reseta();
    bus.contador1 = 4'd3;
    bus.contador2 = 4'd3;
    bus.contador3 = 4'd3;
    trava_todas(1'b1);
    ciclos(1);
    verifica("rst_av_estado", 32'(bus.estado), 1);
    reinicia = 1'b1;
    ciclos(1);
    reinicia = 1'b0;
    ciclos(3);
    verifica("rst_av_credito", 32'(bus.credito), 10);
    verifica("rst_av_rodadas", 32'(bus.rodadas), 0);
    verifica("rst_av_estado0", 32'(bus.estado),  0);
    libera();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
